id_ex_stage: RTL and testbench

Instruction-decode stage and ID/EX pipeline register of the five-stage MIPS pipeline. It sits directly upstream of the execute-stage ALU.

- Decodes the IF/ID instruction and reads the internal 32x32 register file.
- Sign-extends immediates and detects load-use hazards.
- Registers operands, the 6-bit ALU op code and memory/write-back control for the execute stage.
- Supports ADDU, ADDIU, LW, SW and BEQ; every other encoding becomes a bubble.

---
 rtl/id_ex_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//
// Instruction-decode stage plus ID/EX pipeline register for a five-stage
// MIPS pipeline. It decodes ADDU, ADDIU, LW, SW and BEQ, and reads operands
// from an internal 32x32 register file that has a write-back bypass. It also
// detects load-use hazards and registers everything the execute stage needs.
// Any other encoding is turned into a bubble.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   instr             instruction from IF/ID
//   instr_valid       instr holds a real instruction
//   pc_plus4          PC+4 of instr
//   flush             kill the instruction entering ID/EX
//   wb_we/addr/data   register-file write port (write-back stage)
//   stall             combinational; upstream holds PC and IF/ID
//   ex_*              registered ID/EX outputs for the execute stage
// ---------------------------------------------------------------------------
module id_ex_stage #(
    parameter logic [5:0] ADDU_FUNCT = 6'b100001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    input  logic [31:0] pc_plus4,
    input  logic        flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        stall,
    output logic        ex_valid,
    output logic [5:0]  ex_alu_op,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_dest,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic [31:0] ex_branch_target
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // Register file: flops rather than block RAM, because reset must clear
    // every entry asynchronously and reads are combinational.
    logic [31:0] r_rf [32];

    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic [5:0]  w_funct;
    logic        w_is_addu;
    logic        w_is_addiu;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_is_beq;
    logic        w_legal;
    logic        w_uses_rt;
    logic [31:0] w_imm_sext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [4:0]  w_dest;
    logic        w_hazard;
    logic        w_load;

    assign w_op    = instr[31:26];
    assign w_rs    = instr[25:21];
    assign w_rt    = instr[20:16];
    assign w_rd    = instr[15:11];
    assign w_imm   = instr[15:0];
    assign w_funct = instr[5:0];

    assign w_is_addu  = (w_op == OP_RTYPE) && (w_funct == ADDU_FUNCT);
    assign w_is_addiu = (w_op == OP_ADDIU);
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_is_beq   = (w_op == OP_BEQ);
    assign w_legal    = instr_valid &
                        (w_is_addu | w_is_addiu | w_is_lw | w_is_sw | w_is_beq);

    // Instructions that actually consume the rt register value as a source.
    assign w_uses_rt  = w_is_addu | w_is_sw | w_is_beq;

    assign w_imm_sext = {{16{w_imm[15]}}, w_imm};

    // r0 is hard-wired to zero; a same-cycle write-back to a read index is
    // forwarded so the reader sees the new value.
    always_comb begin
        w_rs_val = r_rf[w_rs];
        if (w_rs == 5'd0)
            w_rs_val = '0;
        else if (wb_we && (wb_addr == w_rs))
            w_rs_val = wb_data;

        w_rt_val = r_rf[w_rt];
        if (w_rt == 5'd0)
            w_rt_val = '0;
        else if (wb_we && (wb_addr == w_rt))
            w_rt_val = wb_data;
    end

    always_comb begin
        w_dest = 5'd0;
        if (w_is_addu)
            w_dest = w_rd;
        else if (w_is_addiu || w_is_lw)
            w_dest = w_rt;
    end

    // Load-use: the value the load in EX produces is not yet available for
    // the instruction in ID. Built only from ID/EX state and instr, so there
    // is no combinational path from the write-back port.
    assign w_hazard = ex_mem_read && (ex_dest != 5'd0) &&
                      ((ex_dest == w_rs) || (w_uses_rt && (ex_dest == w_rt)));

    assign stall  = w_hazard & instr_valid & ~flush;
    assign w_load = w_legal & ~flush & ~stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                r_rf[i] <= '0;
        end else if (wb_we && (wb_addr != 5'd0)) begin
            r_rf[wb_addr] <= wb_data;
        end
    end

    // ID/EX register. Flush, stall and illegal/invalid encodings all load
    // the all-zero bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid         <= 1'b0;
            ex_alu_op        <= '0;
            ex_in1           <= '0;
            ex_in2           <= '0;
            ex_store_data    <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            ex_dest          <= '0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_branch        <= 1'b0;
            ex_branch_target <= '0;
        end else if (!w_load) begin
            ex_valid         <= 1'b0;
            ex_alu_op        <= '0;
            ex_in1           <= '0;
            ex_in2           <= '0;
            ex_store_data    <= '0;
            ex_rs            <= '0;
            ex_rt            <= '0;
            ex_dest          <= '0;
            ex_reg_write     <= 1'b0;
            ex_mem_read      <= 1'b0;
            ex_mem_write     <= 1'b0;
            ex_branch        <= 1'b0;
            ex_branch_target <= '0;
        end else begin
            ex_valid         <= 1'b1;
            ex_alu_op        <= w_op;
            ex_in1           <= w_rs_val;
            ex_in2           <= (w_is_addu || w_is_beq) ? w_rt_val : w_imm_sext;
            ex_store_data    <= w_rt_val;
            ex_rs            <= w_rs;
            ex_rt            <= w_rt;
            ex_dest          <= w_dest;
            ex_reg_write     <= w_is_addu | w_is_addiu | w_is_lw;
            ex_mem_read      <= w_is_lw;
            ex_mem_write     <= w_is_sw;
            ex_branch        <= w_is_beq;
            ex_branch_target <= pc_plus4 + {{14{w_imm[15]}}, w_imm, 2'b00};
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [5:0]  ex_alu_op;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_dest;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic [31:0] ex_branch_target;

    id_ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .instr            (instr),
        .instr_valid      (instr_valid),
        .pc_plus4         (pc_plus4),
        .flush            (flush),
        .wb_we            (wb_we),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .stall            (stall),
        .ex_valid         (ex_valid),
        .ex_alu_op        (ex_alu_op),
        .ex_in1           (ex_in1),
        .ex_in2           (ex_in2),
        .ex_store_data    (ex_store_data),
        .ex_rs            (ex_rs),
        .ex_rt            (ex_rt),
        .ex_dest          (ex_dest),
        .ex_reg_write     (ex_reg_write),
        .ex_mem_read      (ex_mem_read),
        .ex_mem_write     (ex_mem_write),
        .ex_branch        (ex_branch),
        .ex_branch_target (ex_branch_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [5:0]  op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] sd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dest;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic [31:0] bt;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [31:0] PC = 32'h40;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'd0, funct};
    endfunction

    function automatic logic [31:0] bt_of(input logic [31:0] pc, input logic [31:0] ins);
        return pc + {{14{ins[15]}}, ins[15:0], 2'b00};
    endfunction

    function automatic exp_t bubble();
        exp_t e;
        e = '{valid: 1'b0, op: 6'd0, in1: 32'd0, in2: 32'd0, sd: 32'd0, rs: 5'd0,
              rt: 5'd0, dest: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b0, bt: 32'd0};
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] ins, input logic [31:0] pc,
                                input logic [31:0] in1, input logic [31:0] in2,
                                input logic [31:0] sd, input logic [4:0] dest,
                                input logic rw, input logic mr, input logic mw, input logic br);
        exp_t e;
        e.valid = 1'b1;
        e.op    = ins[31:26];
        e.in1   = in1;
        e.in2   = in2;
        e.sd    = sd;
        e.rs    = ins[25:21];
        e.rt    = ins[20:16];
        e.dest  = dest;
        e.rw    = rw;
        e.mr    = mr;
        e.mw    = mw;
        e.br    = br;
        e.bt    = bt_of(pc, ins);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cmp_ex(input string step, input exp_t e);
        chk({step, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
        chk({step, ".alu_op"}, {26'd0, ex_alu_op}, {26'd0, e.op});
        chk({step, ".in1"}, ex_in1, e.in1);
        chk({step, ".in2"}, ex_in2, e.in2);
        chk({step, ".store_data"}, ex_store_data, e.sd);
        chk({step, ".rs"}, {27'd0, ex_rs}, {27'd0, e.rs});
        chk({step, ".rt"}, {27'd0, ex_rt}, {27'd0, e.rt});
        chk({step, ".dest"}, {27'd0, ex_dest}, {27'd0, e.dest});
        chk({step, ".ctrl"}, {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch},
            {28'd0, e.rw, e.mr, e.mw, e.br});
        chk({step, ".branch_target"}, ex_branch_target, e.bt);
    endtask

    // Called at posedge+1: drive one cycle of stimulus, check the
    // combinational stall, push the expected ID/EX contents, then compare
    // them after the edge that ends the cycle.
    task automatic issue(input string step, input logic [31:0] ins, input logic v,
                         input logic fl, input logic [31:0] pc, input logic we,
                         input logic [4:0] wa, input logic [31:0] wd,
                         input exp_t e, input logic exp_stall);
        exp_t got;
        instr       = ins;
        instr_valid = v;
        flush       = fl;
        pc_plus4    = pc;
        wb_we       = we;
        wb_addr     = wa;
        wb_data     = wd;
        exp_q.push_back(e);
        #2;
        chk({step, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        cmp_ex(step, got);
        $display("step %s: instr=%h valid=%0b flush=%0b stall=%0b ex_valid=%0b dest=%0d",
                 step, ins, v, fl, exp_stall, ex_valid, ex_dest);
    endtask

    logic [31:0] i_addiu2, i_addu3, i_lw4, i_addu5, i_addu8, i_addiu6, i_addiu4;
    logic [31:0] i_sw9, i_addu10, i_beq, i_bad, i_badfunct, i_addiu5, i_addu11;

    initial begin
        rst         = 1'b1;
        instr       = '0;
        instr_valid = 1'b0;
        pc_plus4    = '0;
        flush       = 1'b0;
        wb_we       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;

        i_addiu2   = enc_i(6'b001001, 5'd1, 5'd2, 16'hFFFD);
        i_addu3    = enc_r(5'd1, 5'd1, 5'd3, 6'b100001);
        i_lw4      = enc_i(6'b100011, 5'd1, 5'd4, 16'h0000);
        i_addu5    = enc_r(5'd4, 5'd1, 5'd5, 6'b100001);
        i_addu8    = enc_r(5'd1, 5'd4, 5'd8, 6'b100001);
        i_addiu6   = enc_i(6'b001001, 5'd4, 5'd6, 16'h0001);
        i_addiu4   = enc_i(6'b001001, 5'd7, 5'd4, 16'h0001);
        i_sw9      = enc_i(6'b101011, 5'd0, 5'd9, 16'h0004);
        i_addu10   = enc_r(5'd0, 5'd9, 5'd10, 6'b100001);
        i_beq      = enc_i(6'b000100, 5'd0, 5'd9, 16'hFFFF);
        i_bad      = enc_i(6'b111111, 5'd1, 5'd2, 16'h1234);
        i_badfunct = enc_r(5'd1, 5'd1, 5'd3, 6'b100000);
        i_addiu5   = enc_i(6'b001001, 5'd1, 5'd5, 16'h0002);
        i_addu11   = enc_r(5'd5, 5'd1, 5'd11, 6'b100001);

        repeat (2) @(posedge clk);
        #1;
        cmp_ex("reset", bubble());
        chk("reset.stall", {31'd0, stall}, 32'd0);
        rst = 1'b0;

        // Write r1 = 7 with no instruction in ID.
        issue("wb_r1", 32'd0, 1'b0, 1'b0, PC, 1'b1, 5'd1, 32'd7, bubble(), 1'b0);
        issue("addiu", i_addiu2, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addiu2, PC, 32'd7, 32'hFFFFFFFD, 32'd0, 5'd2, 1, 0, 0, 0), 1'b0);
        issue("addu", i_addu3, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addu3, PC, 32'd7, 32'd7, 32'd7, 5'd3, 1, 0, 0, 0), 1'b0);

        // Load-use on rs.
        issue("lw_a", i_lw4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_lw4, PC, 32'd7, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0), 1'b0);
        issue("use_rs_stall", i_addu5, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b1);
        issue("use_rs_issue", i_addu5, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addu5, PC, 32'd0, 32'd7, 32'd7, 5'd5, 1, 0, 0, 0), 1'b0);

        // Load-use on rt of an ADDU.
        issue("lw_b", i_lw4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_lw4, PC, 32'd7, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0), 1'b0);
        issue("use_rt_stall", i_addu8, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b1);
        issue("use_rt_issue", i_addu8, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addu8, PC, 32'd7, 32'd0, 32'd0, 5'd8, 1, 0, 0, 0), 1'b0);

        // ADDIU reading the loaded register stalls; writing it does not.
        issue("lw_c", i_lw4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_lw4, PC, 32'd7, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0), 1'b0);
        issue("addiu_rs_stall", i_addiu6, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b1);
        issue("addiu_rs_issue", i_addiu6, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addiu6, PC, 32'd0, 32'd1, 32'd0, 5'd6, 1, 0, 0, 0), 1'b0);
        issue("lw_d", i_lw4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_lw4, PC, 32'd7, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0), 1'b0);
        issue("addiu_rt_nostall", i_addiu4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addiu4, PC, 32'd0, 32'd1, 32'd0, 5'd4, 1, 0, 0, 0), 1'b0);

        // Flush beats a simultaneous hazard.
        issue("lw_e", i_lw4, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_lw4, PC, 32'd7, 32'd0, 32'd0, 5'd4, 1, 1, 0, 0), 1'b0);
        issue("flush_hazard", i_addu5, 1'b1, 1'b1, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b0);

        // Write-back bypass into a store, then writes to r0 are ignored.
        issue("sw_bypass", i_sw9, 1'b1, 1'b0, PC, 1'b1, 5'd9, 32'hDEADBEEF,
              mk(i_sw9, PC, 32'd0, 32'd4, 32'hDEADBEEF, 5'd0, 0, 0, 1, 0), 1'b0);
        issue("r0_write", i_addu10, 1'b1, 1'b0, PC, 1'b1, 5'd0, 32'h00001234,
              mk(i_addu10, PC, 32'd0, 32'hDEADBEEF, 32'hDEADBEEF, 5'd10, 1, 0, 0, 0), 1'b0);

        // BEQ target wraps backwards by one word; r0 still reads 0.
        issue("beq", i_beq, 1'b1, 1'b0, 32'h100, 1'b0, 5'd0, 32'd0,
              '{valid: 1'b1, op: 6'b000100, in1: 32'd0, in2: 32'hDEADBEEF, sd: 32'hDEADBEEF,
                rs: 5'd0, rt: 5'd9, dest: 5'd0, rw: 1'b0, mr: 1'b0, mw: 1'b0, br: 1'b1,
                bt: 32'h000000FC}, 1'b0);

        issue("illegal_op", i_bad, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b0);
        issue("bad_funct", i_badfunct, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b0);
        issue("invalid", i_addu3, 1'b0, 1'b0, PC, 1'b0, 5'd0, 32'd0, bubble(), 1'b0);

        // Reset mid-stream: make ID/EX non-zero and write r5, then assert rst
        // between edges and expect immediate clearing.
        issue("pre_reset", i_addiu5, 1'b1, 1'b0, PC, 1'b1, 5'd5, 32'h00000055,
              mk(i_addiu5, PC, 32'd7, 32'd2, 32'h00000055, 5'd5, 1, 0, 0, 0), 1'b0);
        instr       = '0;
        instr_valid = 1'b0;
        wb_we       = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        cmp_ex("async_reset", bubble());
        chk("async_reset.stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue("post_reset", i_addu11, 1'b1, 1'b0, PC, 1'b0, 5'd0, 32'd0,
              mk(i_addu11, PC, 32'd0, 32'd0, 32'd0, 5'd11, 1, 0, 0, 0), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
